vid_mem_arbiter: RTL and testbench
==================================

# vid_mem_arbiter

Arbiter and scheduler for write port 1 of the video text memory (`vidMemory`, 2048 x 18). It shares the port between the display glyph-fetch path and two write requesters:
- requester 0: CPU store to the text buffer;
- requester 1: debug-snapshot sequencer that writes register and instruction glyph codes.

Accepted writes are buffered in a small FIFO and drained only during display blanking, so the glyph fetch never sees a collision.

## Interface
Parameters:
- `AW`, 11, memory address width
- `DW`, 18, memory data width (three 6-bit glyph codes)
- `DEPTH`, 4, write FIFO entries (power of 2)
- `MAX_ADDR`, 1875, highest writable address; anything above it is rejected
- `GUARD_CYC`, 2, CLK cycles after `blank` rises before the first write

Ports:
- `CLK` in 1 — single clock
- `CLR` in 1 — reset, asynchronous, active-low
- `blank` in 1 — 1 while the display is not fetching glyphs (HPix==0 or VPix==0 region)
- `disp_addr` in AW — display glyph-fetch address
- `req0_valid` in 1; `req0_addr` in AW; `req0_data` in DW; `req0_ready` out 1 — CPU write channel
- `req1_valid` in 1; `req1_addr` in AW; `req1_data` in DW; `req1_ready` out 1 — debug-snapshot channel
- `mem_we` out 1; `mem_addr` out AW; `mem_din` out DW — memory port 1
- `fifo_cnt` out clog2(DEPTH)+1 — entries pending
- `err` out 1 — one-cycle pulse, out-of-range write was dropped

## Operation
Admission (round-robin):
- Register `last` holds the requester granted most recently.
- Candidate = the valid requester; if both are valid, candidate = `~last`.
- `reqN_ready` = (candidate==N) && (registered `fifo_cnt` < DEPTH).
- A transfer occurs on valid && ready. On a transfer, `last` <= N.
- `valid` must not depend on `ready`. A requester holds addr/data stable until its transfer.
- Accepted transfer with addr > MAX_ADDR: consumed, not enqueued, `err`=1 on the next cycle.

State machine `st`:
- DISP: blank=0. On `blank`=1, go to GUARD with guard counter = 0.
- GUARD: counter increments each cycle. At counter == GUARD_CYC-1, go to DRAIN. If `blank`=0, go to DISP.
- DRAIN: if `blank`=0, go to DISP.

Memory port, combinational:
- When `st`==DRAIN && `blank` && FIFO non-empty: `mem_we`=1, addr/din = FIFO head. The head pops on the same edge.
- Otherwise: `mem_we`=0, `mem_addr`=`disp_addr`, `mem_din`=0.

FIFO rules:
- Push and pop in the same cycle: count unchanged.
- When full, no push is possible, even if a pop happens in that cycle. Ready uses the registered count.
- Pointers wrap modulo DEPTH.
- Order is preserved: entries write in acceptance order.

## Timing
- Reset values: `st`=DISP, FIFO empty, `fifo_cnt`=0, `last`=1 (so req0 wins the first tie), `err`=0, `mem_we`=0, `req*_ready`=1 once out of reset with FIFO empty and that requester valid.
- Latency, acceptance to memory write: at least 1 cycle. In DRAIN with an empty FIFO, an entry accepted at edge k is written in cycle k+1.
- After `blank` rises, the first possible `mem_we` is exactly GUARD_CYC cycles later.
- When `blank` falls, `mem_we` drops in the same cycle. The entry not yet written remains at the head.
- Throughput: one write per cycle in DRAIN, one acceptance per cycle.
- Reset mid-operation: pending entries are discarded and `mem_we` drops immediately (asynchronous).
- An out-of-range request does not change FIFO state. It still updates `last`.

## Structure
- Package `vid_pkg` holds:
  - `VID_AW`=11, `VID_DW`=18, `VID_MAX_ADDR`=1875, `VID_GLYPH_BASE`=256;
  - `vid_arb_st_t` {DISP, GUARD, DRAIN};
  - struct `vid_wr_t` {addr, data}.
- Sub-module `vid_wr_fifo`: synchronous FIFO (DEPTH x `vid_wr_t`), push/pop/count/full/empty, async active-low reset.
- The top level contains the arbiter, the state machine, and the port mux.

## Test plan
- Reset, `blank`=0, req0 writes addr 321 data 0x01234 → accepted, `fifo_cnt`=1, `mem_we` stays 0, `mem_addr` tracks `disp_addr`.
- With 321 pending, raise `blank` → `mem_we`=1 exactly 2 cycles later with addr 321 data 0x01234. `fifo_cnt` returns to 0.
- Both requesters valid continuously, `blank`=0 → grants alternate req0, req1, req0, req1. The FIFO then fills to 4 and both ready signals deassert. Memory writes in DRAIN follow the same order.
- req1 writes addr 1876 → `req1_ready`=1, `err` pulses 1 cycle later, `fifo_cnt` unchanged.
- 3 entries pending, DRAIN active, `blank` falls after the first write → `mem_we`=0 in the same cycle. The 2 remaining entries are written in order after the next blank + guard.
- Assert `CLR`=0 with 2 entries pending in DRAIN → `mem_we`=0 immediately, `fifo_cnt`=0, `st`=DISP after release.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and constants for the video text memory write-port arbiter.
package vid_pkg;

  localparam int VID_AW         = 11;
  localparam int VID_DW         = 18;
  localparam int VID_MAX_ADDR   = 1875;
  localparam int VID_GLYPH_BASE = 256;

  typedef enum logic [1:0] {
    DISP,
    GUARD,
    DRAIN
  } vid_arb_st_t;

  typedef struct packed {
    logic [VID_AW-1:0] addr;
    logic [VID_DW-1:0] data;
  } vid_wr_t;

endpackage

// File: rtl/vid_mem_arbiter_if.sv
// Requester channels, memory write port and status of the text-memory arbiter.
interface vid_mem_arbiter_if
  import vid_pkg::*;
#(
  parameter int AW    = VID_AW,
  parameter int DW    = VID_DW,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          blank;
  logic [AW-1:0] disp_addr;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  logic [CW-1:0] fifo_cnt;
  logic          err;

  modport slave (
    input  blank, disp_addr,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output mem_we, mem_addr, mem_din,
    output fifo_cnt, err
  );

  modport master (
    output blank, disp_addr,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  mem_we, mem_addr, mem_din,
    input  fifo_cnt, err
  );

endinterface

// File: rtl/vid_wr_fifo.sv
// Small write FIFO with a combinational head, so a popped entry reaches the
// memory port in the same cycle it is selected.
module vid_wr_fifo
  import vid_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          push,
  input  logic          pop,
  input  vid_wr_t       din,
  output vid_wr_t       dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  vid_wr_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/vid_mem_arbiter.sv
// Round-robin admission of CPU and debug-snapshot writes into a FIFO that is
// drained into the text memory only while the display is blanked.
module vid_mem_arbiter
  import vid_pkg::*;
#(
  parameter int AW        = VID_AW,
  parameter int DW        = VID_DW,
  parameter int DEPTH     = 4,
  parameter int MAX_ADDR  = VID_MAX_ADDR,
  parameter int GUARD_CYC = 2
) (
  input  logic           CLK,
  input  logic           CLR,
  vid_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;

  vid_arb_st_t   st_q, st_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          any_valid, cand;
  logic          xfer, in_range, push, pop;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  vid_wr_t       fifo_din, fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;

  // Admission: a tie goes to the requester not granted last time.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    cand      = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    sel_addr  = cand ? bus.req1_addr : bus.req0_addr;
    sel_data  = cand ? bus.req1_data : bus.req0_data;
    xfer      = any_valid && !fifo_full;
    in_range  = int'(sel_addr) <= MAX_ADDR;
    push      = xfer && in_range;
    err_d     = xfer && !in_range;
    last_d    = xfer ? cand : last_q;
    fifo_din.addr = VID_AW'(sel_addr);
    fifo_din.data = VID_DW'(sel_data);
  end

  assign bus.req0_ready = bus.req0_valid && !cand && !fifo_full;
  assign bus.req1_ready = bus.req1_valid && cand && !fifo_full;

  // The guard count is compared on its next value so the first write lands
  // exactly GUARD_CYC cycles after blank rises.
  always_comb begin
    st_d   = st_q;
    gcnt_d = gcnt_q;
    unique case (st_q)
      DISP: begin
        if (bus.blank) begin
          st_d   = GUARD;
          gcnt_d = '0;
        end
      end
      GUARD: begin
        gcnt_d = gcnt_q + GW'(1);
        if (!bus.blank) begin
          st_d = DISP;
        end else if (int'(gcnt_q) + 1 >= GUARD_CYC - 1) begin
          st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.blank) begin
          st_d = DISP;
        end
      end
      default: st_d = DISP;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      st_q   <= DISP;
      gcnt_q <= '0;
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      gcnt_q <= gcnt_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  // blank gates the write directly so the port is returned within the cycle.
  assign pop = (st_q == DRAIN) && bus.blank && !fifo_empty;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = bus.disp_addr;
    bus.mem_din  = '0;
    if (pop) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = AW'(fifo_dout.addr);
      bus.mem_din  = DW'(fifo_dout.data);
    end
  end

  vid_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .CLR  (CLR),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(fifo_cnt),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bus.fifo_cnt = fifo_cnt;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Directed bench: expected memory writes are queued as stimulus is issued and
// a negedge monitor pops and compares every mem_we cycle.
module tb_vid_mem_arbiter;
  import vid_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vid_mem_arbiter_if #(.AW(11), .DW(18), .DEPTH(4)) bus ();

  vid_mem_arbiter #(
    .AW(11), .DW(18), .DEPTH(4), .MAX_ADDR(1875), .GUARD_CYC(2)
  ) dut (
    .CLK(clk),
    .CLR(rst_n),
    .bus(bus)
  );

  int      tests = 0;
  int      fails = 0;
  vid_wr_t exp_q[$];
  vid_wr_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int addr, input int data);
    vid_wr_t e;
    e.addr = 11'(addr);
    e.data = 18'(data);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mem_wr: unexpected write addr %0d data 0x%0h", bus.mem_addr, bus.mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mem_addr !== mon_e.addr || bus.mem_din !== mon_e.data) begin
          fails++;
          $display("FAIL mem_wr: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   bus.mem_addr, bus.mem_din, mon_e.addr, mon_e.data);
        end else begin
          $display("[TB] mem write addr %0d data 0x%0h", bus.mem_addr, bus.mem_din);
        end
      end
    end
  end

  int a0, a1;

  initial begin
    bus.blank      = 1'b0;
    bus.disp_addr  = 11'd100;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_fifo_cnt", bus.fifo_cnt, 0);
    check("rst_err", bus.err, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 100);
    check("rst_mem_din", bus.mem_din, 0);

    // Single CPU write while displaying
    tick();
    bus.req0_valid = 1'b1; bus.req0_addr = 11'd321; bus.req0_data = 18'h01234;
    #1;
    check("t1_req0_ready", bus.req0_ready, 1);
    check("t1_req1_ready", bus.req1_ready, 0);
    expect_wr(321, 'h01234);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t1_fifo_cnt", bus.fifo_cnt, 1);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_mem_addr", bus.mem_addr, 100);
    bus.disp_addr = 11'd555;
    #1;
    check("t1_mem_addr_track", bus.mem_addr, 555);

    // Blank rises: first write exactly two cycles later
    tick();
    bus.blank = 1'b1;
    @(negedge clk);
    check("t2_we_c0", bus.mem_we, 0);
    tick();
    @(negedge clk);
    check("t2_we_c1", bus.mem_we, 0);
    tick();
    @(negedge clk);
    check("t2_we_c2", bus.mem_we, 1);
    tick();
    @(negedge clk);
    check("t2_fifo_cnt", bus.fifo_cnt, 0);
    check("t2_we_after", bus.mem_we, 0);
    tick();
    bus.blank = 1'b0;

    // Round-robin from reset: req0, req1, req0, req1, then full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a0 = 0; a1 = 0;
    bus.req0_valid = 1'b1; bus.req0_addr = 11'd10; bus.req0_data = 18'h100;
    bus.req1_valid = 1'b1; bus.req1_addr = 11'd20; bus.req1_data = 18'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_ready0_g%0d", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_ready1_g%0d", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) expect_wr(10 + a0, 'h100 + a0);
      else            expect_wr(20 + a1, 'h200 + a1);
      tick();
      if (i % 2 == 0) begin
        a0++;
        bus.req0_addr = 11'(10 + a0); bus.req0_data = 18'(32'h100 + a0);
      end else begin
        a1++;
        bus.req1_addr = 11'(20 + a1); bus.req1_data = 18'(32'h200 + a1);
      end
    end
    #1;
    check("t3_fifo_full_cnt", bus.fifo_cnt, 4);
    check("t3_full_ready0", bus.req0_ready, 0);
    check("t3_full_ready1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    bus.blank = 1'b1;
    repeat (7) tick();
    @(negedge clk);
    check("t3_drained_cnt", bus.fifo_cnt, 0);
    check("t3_sb_empty", exp_q.size(), 0);
    tick();
    bus.blank = 1'b0;

    // Out-of-range write on req1, then the highest legal address on req0
    bus.req1_valid = 1'b1; bus.req1_addr = 11'd1876; bus.req1_data = 18'h3FFFF;
    #1;
    check("t4_req1_ready", bus.req1_ready, 1);
    check("t4_err_before", bus.err, 0);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t4_err_pulse", bus.err, 1);
    check("t4_fifo_cnt", bus.fifo_cnt, 0);
    tick();
    @(negedge clk);
    check("t4_err_clear", bus.err, 0);
    tick();
    bus.req0_valid = 1'b1; bus.req0_addr = 11'd1875; bus.req0_data = 18'h2AAAA;
    #1;
    check("t4_max_ready0", bus.req0_ready, 1);
    expect_wr(1875, 'h2AAAA);
    tick();
    bus.req0_addr = 11'd30; bus.req0_data = 18'h00011;
    expect_wr(30, 'h11);
    tick();
    bus.req0_addr = 11'd31; bus.req0_data = 18'h00022;
    expect_wr(31, 'h22);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t4_err_inrange", bus.err, 0);
    check("t5_pending", bus.fifo_cnt, 3);

    // Blank falls after the first drained write
    tick();
    bus.blank = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("t5_first_we", bus.mem_we, 1);
    tick();
    bus.blank = 1'b0;
    #1;
    check("t5_we_drop", bus.mem_we, 0);
    check("t5_addr_disp", bus.mem_addr, 555);
    check("t5_remaining", bus.fifo_cnt, 2);
    repeat (3) tick();
    bus.blank = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("t5_drained_cnt", bus.fifo_cnt, 0);
    check("t5_sb_empty", exp_q.size(), 0);
    tick();
    bus.blank = 1'b0;

    // Asynchronous reset in DRAIN with two entries pending (never written)
    bus.req0_valid = 1'b1; bus.req0_addr = 11'd40; bus.req0_data = 18'h00040;
    tick();
    bus.req0_addr = 11'd41; bus.req0_data = 18'h00041;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("t6_pending", bus.fifo_cnt, 2);
    tick();
    bus.blank = 1'b1;
    tick();
    tick();
    check("t6_pre_rst_we", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", bus.mem_we, 0);
    check("t6_rst_cnt", bus.fifo_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 11'd50; bus.req0_data = 18'h00055;
    #1;
    check("t6_post_ready0", bus.req0_ready, 1);
    expect_wr(50, 'h55);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t6_guard_we", bus.mem_we, 0);
    check("t6_post_cnt", bus.fifo_cnt, 1);
    tick();
    @(negedge clk);
    check("t6_drain_we", bus.mem_we, 1);
    tick();
    @(negedge clk);
    check("t6_final_cnt", bus.fifo_cnt, 0);
    bus.blank = 1'b0;
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
